// File: rtl/pe_array_cfg_ctrl_pkg.sv
// Shared definitions for the PE-array configuration sequencer.
// PE_INST_W / BUFFER_DEPTH mirror the PE instruction width and per-PE config
// buffer depth; the FSM state encoding and a step-count legality helper live here.
package pe_array_cfg_ctrl_pkg;

    // Must track the PE instruction width and config buffer depth of the PE design.
    localparam int PE_INST_W    = 28;
    localparam int BUFFER_DEPTH = 16;
    localparam int DEF_NUM_PE   = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RUN   = 3'd4,
        ST_FIN   = 3'd5
    } state_t;

    // A program must hold at least one instruction and fit in a PE buffer.
    function automatic logic steps_legal(input int unsigned n, input int unsigned depth);
        return (n != 0) && (n <= depth);
    endfunction

endpackage

// File: rtl/pe_array_cfg_ctrl_if.sv
// Config-memory read port plus the PE-array control bundle.
// master = sequencer (drives reads, inst/init/run/rst); slave = memory + PE array.
// Read data returns exactly one cycle after cfg_rd_en; no backpressure.
interface pe_array_cfg_ctrl_if
    import pe_array_cfg_ctrl_pkg::*;
#(
    parameter int NUM_PE = DEF_NUM_PE,
    parameter int INST_W = PE_INST_W,
    parameter int AW     = $clog2(DEF_NUM_PE * BUFFER_DEPTH)
) ();

    logic              cfg_rd_en;
    logic [AW-1:0]     cfg_rd_addr;
    logic [INST_W-1:0] cfg_rd_data;
    logic [INST_W-1:0] pe_inst;
    logic [NUM_PE-1:0] pe_init;
    logic              pe_run;
    logic              pe_rst;

    modport master (
        output cfg_rd_en, cfg_rd_addr, pe_inst, pe_init, pe_run, pe_rst,
        input  cfg_rd_data
    );

    modport slave (
        input  cfg_rd_en, cfg_rd_addr, pe_inst, pe_init, pe_run, pe_rst,
        output cfg_rd_data
    );

endinterface

// File: rtl/pe_array_cfg_ctrl_cfg_addr_gen.sv
// Nested pe/step counter producing config-memory read addresses (pe*DEPTH+step).
// Latency: address is a direct decode of the counter registers; advances on i_adv.
// Backpressure: none; i_clr has priority and returns both counters to zero.
// Ports: i_clr, i_adv, i_steps (program length) -> o_addr, o_pe_idx, o_last.
module cfg_addr_gen #(
    parameter int NUM_PE = 4,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(NUM_PE * DEPTH),
    parameter int SW     = $clog2(DEPTH) + 1,
    parameter int PW     = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_adv,
    input  logic [SW-1:0] i_steps,
    output logic [AW-1:0] o_addr,
    output logic [PW-1:0] o_pe_idx,
    output logic          o_last
);

    localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0] r_pe_cnt;
    logic [CW-1:0] r_step_cnt;
    logic          w_step_last;
    logic          w_pe_last;

    assign w_step_last = (SW'(r_step_cnt) == (i_steps - SW'(1)));
    assign w_pe_last   = (r_pe_cnt == PW'(NUM_PE - 1));

    assign o_addr   = (AW'(r_pe_cnt) * AW'(DEPTH)) + AW'(r_step_cnt);
    assign o_pe_idx = r_pe_cnt;
    assign o_last   = w_step_last && w_pe_last;

    // Both counters wrap to zero after the final issue, so the address bus
    // rests at 0 between programs.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_pe_cnt   <= '0;
            r_step_cnt <= '0;
        end else if (i_adv) begin
            if (w_step_last) begin
                r_step_cnt <= '0;
                r_pe_cnt   <= w_pe_last ? '0 : r_pe_cnt + PW'(1);
            end else begin
                r_step_cnt <= r_step_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/pe_array_cfg_ctrl.sv
// Sequencer: resets the PE array, streams NUM_PE*steps instructions into PE
// buffers via one-hot init strobes, then broadcasts run for steps cycles.
// Latency: start@0 -> pe_rst@1, first read@2, inits@3..2+L, run@3+L.., done@3+L+steps.
// Backpressure: none; start is only sampled in IDLE, abort cancels any operation.
// Ports: i_start/i_abort/i_num_steps in; io_bus (cfg memory + PE controls);
//        o_busy (non-IDLE, drops with done), o_done / o_err one-cycle pulses.
module pe_array_cfg_ctrl
    import pe_array_cfg_ctrl_pkg::*;
#(
    parameter int NUM_PE = DEF_NUM_PE,
    parameter int INST_W = PE_INST_W,
    parameter int DEPTH  = BUFFER_DEPTH,
    parameter int AW     = $clog2(NUM_PE * DEPTH),
    parameter int SW     = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic                     i_abort,
    input  logic [SW-1:0]            i_num_steps,
    pe_array_cfg_ctrl_if.master      io_bus,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err
);

    localparam int PW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    state_t            r_state;
    state_t            w_nxt_state;
    logic              r_abrt;
    logic              w_nxt_abrt;
    logic              w_err;
    logic              w_steps_ok;
    logic              w_run_last;
    logic [SW-1:0]     r_steps;
    logic [SW-1:0]     r_run_cnt;

    logic              w_last_issue;
    logic [PW-1:0]     w_pe_idx;
    logic [AW-1:0]     w_rd_addr;
    logic              w_load;

    logic              r_cfg_rd_en;
    logic [NUM_PE-1:0] r_pe_init;
    logic              r_pe_run;
    logic              r_pe_rst;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    assign w_load     = (r_state == ST_LOAD);
    assign w_steps_ok = steps_legal(32'(i_num_steps), 32'(DEPTH));
    assign w_run_last = (r_run_cnt == (r_steps - SW'(1)));

    cfg_addr_gen #(
        .NUM_PE (NUM_PE),
        .DEPTH  (DEPTH),
        .AW     (AW),
        .SW     (SW),
        .PW     (PW)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (!w_load || i_abort),
        .i_adv    (w_load),
        .i_steps  (r_steps),
        .o_addr   (w_rd_addr),
        .o_pe_idx (w_pe_idx),
        .o_last   (w_last_issue)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_abrt  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_abrt  <= w_nxt_abrt;
        end
    end

    // Next state. An abort reuses CLR to pulse pe_rst once; r_abrt then
    // steers CLR back to IDLE instead of into LOAD.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_abrt  = r_abrt;
        w_err       = 1'b0;
        if (i_abort && (r_state != ST_IDLE)) begin
            w_nxt_state = ST_CLR;
            w_nxt_abrt  = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start && !i_abort) begin
                        if (w_steps_ok) begin
                            w_nxt_state = ST_CLR;
                            w_nxt_abrt  = 1'b0;
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                end
                ST_CLR:   w_nxt_state = r_abrt ? ST_IDLE : ST_LOAD;
                ST_LOAD:  if (w_last_issue) w_nxt_state = ST_DRAIN;
                ST_DRAIN: w_nxt_state = ST_RUN;
                ST_RUN:   if (w_run_last) w_nxt_state = ST_FIN;
                ST_FIN:   w_nxt_state = ST_IDLE;
                default:  w_nxt_state = ST_IDLE;
            endcase
        end
    end

    // Program length and run-cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_steps   <= '0;
            r_run_cnt <= '0;
        end else begin
            if ((r_state == ST_IDLE) && (w_nxt_state == ST_CLR))
                r_steps <= i_num_steps;
            r_run_cnt <= (r_state == ST_RUN) ? r_run_cnt + SW'(1) : '0;
        end
    end

    // Outputs are registered from the next state so each strobe lines up with
    // the state it belongs to. The init strobe is the read issued one cycle
    // earlier, matching the memory's one-cycle read latency; an abort kills
    // the read still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_rd_en <= 1'b0;
            r_pe_init   <= '0;
            r_pe_run    <= 1'b0;
            r_pe_rst    <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_cfg_rd_en <= (w_nxt_state == ST_LOAD);
            r_pe_init   <= (w_load && !i_abort) ? (NUM_PE'(1) << w_pe_idx) : '0;
            r_pe_run    <= (w_nxt_state == ST_RUN);
            r_pe_rst    <= (w_nxt_state == ST_CLR);
            // busy falls together with done so the host may restart right after.
            r_busy      <= (w_nxt_state != ST_IDLE) && (w_nxt_state != ST_FIN);
            r_done      <= (w_nxt_state == ST_FIN);
            r_err       <= w_err;
        end
    end

    assign io_bus.cfg_rd_en   = r_cfg_rd_en;
    assign io_bus.cfg_rd_addr = w_rd_addr;
    assign io_bus.pe_inst     = io_bus.cfg_rd_data;
    assign io_bus.pe_init     = r_pe_init;
    assign io_bus.pe_run      = r_pe_run;
    assign io_bus.pe_rst      = r_pe_rst;
    assign o_busy             = r_busy;
    assign o_done             = r_done;
    assign o_err              = r_err;

endmodule

// File: tb/tb_pe_array_cfg_ctrl.sv
// Scoreboard bench for pe_array_cfg_ctrl (NUM_PE=4, DEPTH=4, word = 0x100+addr).
module tb_pe_array_cfg_ctrl;

    localparam int NP = 4;
    localparam int DP = 4;
    localparam int IW = 28;
    localparam int AW = 4;
    localparam int SW = 3;

    localparam int K_RST  = 0;
    localparam int K_RD   = 1;
    localparam int K_INIT = 2;
    localparam int K_RUN  = 3;
    localparam int K_DONE = 4;
    localparam int K_ERR  = 5;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] v1;
        logic [31:0] v2;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic [SW-1:0] i_num_steps = '0;
    logic          o_busy, o_done, o_err;

    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    bit  mon_en = 1'b0;
    int  exp_lo = 1;
    int  exp_hi = 0;
    ev_t q[$];

    pe_array_cfg_ctrl_if #(.NUM_PE(NP), .INST_W(IW), .AW(AW)) bus ();

    pe_array_cfg_ctrl #(
        .NUM_PE(NP), .INST_W(IW), .DEPTH(DP), .AW(AW), .SW(SW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .i_num_steps (i_num_steps),
        .io_bus      (bus),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Configuration memory: word at address a is 0x100 + a, one-cycle latency.
    always @(posedge clk) begin
        if (bus.cfg_rd_en)
            bus.cfg_rd_data <= IW'(32'h100 + 32'(bus.cfg_rd_addr));
    end

    function automatic string kname(int k);
        case (k)
            K_RST:  return "pe_rst";
            K_RD:   return "cfg_read";
            K_INIT: return "pe_init";
            K_RUN:  return "pe_run";
            K_DONE: return "done";
            default: return "err";
        endcase
    endfunction

    // Keep the expectation queue ordered by (cycle, kind).
    function automatic void push_ev(int c, int k, logic [31:0] a, logic [31:0] b);
        ev_t e;
        int  i;
        e.cyc = c; e.kind = k; e.v1 = a; e.v2 = b;
        i = 0;
        while (i < q.size() && (q[i].cyc < c || (q[i].cyc == c && q[i].kind <= k)))
            i++;
        q.insert(i, e);
    endfunction

    // Reference model for a start issued with the bench at cycle c0.
    function automatic void model_start(int c0, int n);
        int l;
        if (n < 1 || n > DP) begin
            push_ev(c0 + 1, K_ERR, 0, 0);
            return;
        end
        l = NP * n;
        push_ev(c0 + 1, K_RST, 0, 0);
        for (int i = 0; i < l; i++) begin
            int p = i / n;
            int a = p * DP + (i % n);
            push_ev(c0 + 2 + i, K_RD, a, 0);
            push_ev(c0 + 3 + i, K_INIT, 32'(1) << p, 32'h100 + a);
        end
        for (int k = 0; k < n; k++)
            push_ev(c0 + 3 + l + k, K_RUN, 0, 0);
        push_ev(c0 + 3 + l + n, K_DONE, 0, 0);
        exp_lo = c0 + 1;
        exp_hi = c0 + 2 + l + n;
    endfunction

    function automatic void model_abort(int ca);
        while (q.size() > 0 && q[q.size()-1].cyc > ca)
            void'(q.pop_back());
        push_ev(ca + 1, K_RST, 0, 0);
        exp_hi = ca + 1;
    endfunction

    function automatic void observe(int k, logic [31:0] a, logic [31:0] b);
        while (q.size() > 0 && q[0].cyc == cyc && q[0].kind < k) begin
            checks++; failures++;
            $display("FAIL missing %s cyc=%0d got none required v1=%h v2=%h",
                     kname(q[0].kind), cyc, q[0].v1, q[0].v2);
            void'(q.pop_front());
        end
        checks++;
        if (q.size() > 0 && q[0].cyc == cyc && q[0].kind == k) begin
            if (q[0].v1 !== a || q[0].v2 !== b) begin
                failures++;
                $display("FAIL %s cyc=%0d got v1=%h v2=%h required v1=%h v2=%h",
                         kname(k), cyc, a, b, q[0].v1, q[0].v2);
            end
            void'(q.pop_front());
        end else begin
            failures++;
            $display("FAIL unexpected %s cyc=%0d got v1=%h v2=%h required none",
                     kname(k), cyc, a, b);
        end
    endfunction

    // Monitor: samples on the falling edge, stimulus moves at falling edge + 1.
    always @(negedge clk) begin
        if (mon_en) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                checks++; failures++;
                $display("FAIL missing %s cyc=%0d got none required v1=%h v2=%h",
                         kname(q[0].kind), q[0].cyc, q[0].v1, q[0].v2);
                void'(q.pop_front());
            end
            if (bus.pe_rst)        observe(K_RST, 0, 0);
            if (bus.cfg_rd_en)     observe(K_RD, 32'(bus.cfg_rd_addr), 0);
            if (bus.pe_init != '0) observe(K_INIT, 32'(bus.pe_init), 32'(bus.pe_inst));
            if (bus.pe_run)        observe(K_RUN, 0, 0);
            if (o_done)            observe(K_DONE, 0, 0);
            if (o_err)             observe(K_ERR, 0, 0);
            checks++;
            if (o_busy !== (cyc >= exp_lo && cyc <= exp_hi)) begin
                failures++;
                $display("FAIL busy cyc=%0d got %b required %b", cyc, o_busy,
                         (cyc >= exp_lo && cyc <= exp_hi));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got %h required %h", name, got, req);
        end
    endtask

    task automatic do_start(int n);
        i_start = 1'b1;
        i_num_steps = SW'(n);
        model_start(cyc, n);
        tick();
        i_start = 1'b0;
    endtask

    task automatic do_abort();
        if (cyc >= exp_lo && cyc <= exp_hi)
            model_abort(cyc);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
    endtask

    task automatic wait_cyc(int t);
        while (cyc < t) tick();
    endtask

    task automatic wait_idle();
        while (cyc <= exp_hi + 1) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got no finish required finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, n, op;
        repeat (3) tick();
        chk("rst_rd_en",   32'(bus.cfg_rd_en), 0);
        chk("rst_rd_addr", 32'(bus.cfg_rd_addr), 0);
        chk("rst_pe_init", 32'(bus.pe_init), 0);
        chk("rst_pe_run",  32'(bus.pe_run), 0);
        chk("rst_pe_rst",  32'(bus.pe_rst), 1);
        chk("rst_busy",    32'(o_busy), 0);
        chk("rst_done",    32'(o_done), 0);
        chk("rst_err",     32'(o_err), 0);
        rst = 1'b0;
        tick();
        mon_en = 1'b1;
        tick();

        // Directed: two steps, full depth, illegal counts.
        do_start(2); wait_idle();
        do_start(4); wait_idle();
        do_start(0); tick(); tick();
        do_start(5); tick(); tick();

        // Abort mid-LOAD at start+6, then a clean reload.
        c0 = cyc; do_start(2); wait_cyc(c0 + 6); do_abort(); wait_idle();
        do_start(2); wait_idle();

        // Start pulses during RUN and in the done cycle are ignored.
        c0 = cyc; do_start(3);
        wait_cyc(c0 + 3 + NP * 3 + 1);
        i_start = 1'b1; i_num_steps = 3'd1; tick(); i_start = 1'b0;
        wait_cyc(c0 + 3 + NP * 3 + 3);
        i_start = 1'b1; tick(); i_start = 1'b0;
        wait_idle();
        do_start(3); wait_idle();

        // Abort in IDLE, and abort with start in IDLE: no effect.
        i_abort = 1'b1; tick(); i_abort = 1'b0;
        i_abort = 1'b1; i_start = 1'b1; i_num_steps = 3'd2; tick();
        i_abort = 1'b0; i_start = 1'b0; tick(); tick();

        // Randomized mix.
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 4);
            if (op <= 1) begin
                n = $urandom_range(1, DP);
                c0 = cyc; do_start(n);
                if ($urandom_range(0, 1) == 1) begin
                    wait_cyc(c0 + 3 + NP * n + $urandom_range(0, n));
                    i_start = 1'b1; i_num_steps = SW'($urandom_range(1, DP));
                    tick(); i_start = 1'b0;
                end
                wait_idle();
            end else if (op == 2) begin
                n = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(DP + 1, 7);
                do_start(n); tick();
            end else if (op == 3) begin
                n = $urandom_range(1, DP);
                c0 = cyc; do_start(n);
                wait_cyc($urandom_range(c0 + 1, exp_hi));
                do_abort(); wait_idle();
            end else begin
                i_abort = 1'b1; i_start = $urandom_range(0, 1) == 1;
                i_num_steps = SW'($urandom_range(1, DP));
                tick(); i_abort = 1'b0; i_start = 1'b0; tick();
            end
        end

        // Synchronous reset in the middle of RUN.
        c0 = cyc; do_start(3);
        wait_cyc(c0 + 3 + NP * 3 + 1);
        mon_en = 1'b0; q.delete(); exp_lo = 1; exp_hi = 0;
        rst = 1'b1;
        tick();
        chk("midrst_pe_run",  32'(bus.pe_run), 0);
        chk("midrst_pe_rst",  32'(bus.pe_rst), 1);
        chk("midrst_busy",    32'(o_busy), 0);
        chk("midrst_pe_init", 32'(bus.pe_init), 0);
        chk("midrst_rd_en",   32'(bus.cfg_rd_en), 0);
        chk("midrst_done",    32'(o_done), 0);
        rst = 1'b0;
        tick();
        mon_en = 1'b1;
        tick();
        do_start(2); wait_idle();
        repeat (3) tick();

        while (q.size() > 0) begin
            checks++; failures++;
            $display("FAIL leftover %s cyc=%0d got none required v1=%h v2=%h",
                     kname(q[0].kind), q[0].cyc, q[0].v1, q[0].v2);
            void'(q.pop_front());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
